// File: rtl/run_ctrl_pkg.sv
// Shared state encoding and tohost decode constants for the CPU run controller.
package run_ctrl_pkg;

    typedef enum logic [1:0] {
        HOLD = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam int TOHOST_PASS = 1;
    localparam int EXIT_SHIFT  = 1;

endpackage

// File: rtl/run_ctrl_sat_cnt.sv
// Saturating up-counter: clear has priority over increment, value sticks at all-ones.
module run_ctrl_sat_cnt #(
    parameter int W = 32
) (
    input  logic         clk,
    input  logic         reset_n,
    input  logic         clr,
    input  logic         inc,
    output logic [W-1:0] value
);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            value <= '0;
        end else if (clr) begin
            value <= '0;
        end else if (inc && (value != '1)) begin
            value <= value + 1'b1;
        end
    end

endmodule

// File: rtl/cpu_run_ctrl.sv
// Run controller for cpu_top: reset sequencing, cycle/instret counting, end-of-run detection.
// Optional retire-stall watchdog is built when RUN_CTRL_STALL_WD_EN is defined.
module cpu_run_ctrl
    import run_ctrl_pkg::*;
#(
    parameter int                ADDR_W       = 32,
    parameter int                DATA_W       = 32,
    parameter int                CNT_W        = 32,
    parameter int                RESET_CYCLES = 2,
    parameter int                MAX_CYCLES   = 1000,
    parameter logic [ADDR_W-1:0] TOHOST_ADDR  = 'h0000_1000,
    parameter int                STALL_CYCLES = 64
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              restart,
    input  logic              retire,
    input  logic              mon_valid,
    input  logic [ADDR_W-1:0] mon_addr,
    input  logic [DATA_W-1:0] mon_data,
    output logic              cpu_reset,
    output logic [CNT_W-1:0]  cycle_cnt,
    output logic [CNT_W-1:0]  instret_cnt,
    output logic              done,
    output logic              pass,
    output logic              timeout,
    output logic              stalled,
    output logic [DATA_W-1:0] exit_code
);

    localparam int HOLD_W = $clog2(RESET_CYCLES) + 1;
    // Timeout runs off its own timer so a narrow CNT_W cannot hide the budget.
    localparam int TMR_W  = $clog2(MAX_CYCLES) + 1;

    state_t            state, state_nx;
    logic [HOLD_W-1:0] hold_cnt;
    logic [TMR_W-1:0]  run_tmr;
    logic              in_run, restart_ok;
    logic              tohost_hit, tohost_pass, stall_hit, timeout_hit;

    assign in_run      = (state == RUN);
    assign restart_ok  = (state == DONE) && restart;
    assign tohost_hit  = in_run && mon_valid && (mon_addr == TOHOST_ADDR) && (mon_data != '0);
    assign tohost_pass = (mon_data == DATA_W'(TOHOST_PASS));
    assign timeout_hit = in_run && (run_tmr == TMR_W'(MAX_CYCLES - 1));

    run_ctrl_sat_cnt #(.W(CNT_W)) u_cycle_cnt (
        .clk, .reset_n, .clr(restart_ok), .inc(in_run), .value(cycle_cnt)
    );

    run_ctrl_sat_cnt #(.W(CNT_W)) u_instret_cnt (
        .clk, .reset_n, .clr(restart_ok), .inc(in_run && retire), .value(instret_cnt)
    );

    run_ctrl_sat_cnt #(.W(TMR_W)) u_run_tmr (
        .clk, .reset_n, .clr(restart_ok), .inc(in_run), .value(run_tmr)
    );

`ifdef RUN_CTRL_STALL_WD_EN
    localparam int STALL_W = $clog2(STALL_CYCLES) + 1;
    logic [STALL_W-1:0] stall_cnt;

    // Counts retire-free RUN cycles; the hit fires on the STALL_CYCLES-th one.
    run_ctrl_sat_cnt #(.W(STALL_W)) u_stall_cnt (
        .clk, .reset_n,
        .clr(restart_ok || (in_run && retire)),
        .inc(in_run && !retire),
        .value(stall_cnt)
    );

    assign stall_hit = in_run && !retire && (stall_cnt == STALL_W'(STALL_CYCLES - 1));
`else
    logic stall_unused;
    assign stall_unused = (STALL_CYCLES != 0);
    assign stall_hit    = 1'b0;
`endif

    always_comb begin
        state_nx = state;
        unique case (state)
            HOLD:    if (hold_cnt == HOLD_W'(RESET_CYCLES - 1)) state_nx = RUN;
            RUN:     if (tohost_hit || stall_hit || timeout_hit) state_nx = DONE;
            DONE:    if (restart) state_nx = HOLD;
            default: state_nx = HOLD;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state     <= HOLD;
            hold_cnt  <= '0;
            cpu_reset <= 1'b1;
            done      <= 1'b0;
            pass      <= 1'b0;
            timeout   <= 1'b0;
            stalled   <= 1'b0;
            exit_code <= '0;
        end else begin
            state     <= state_nx;
            hold_cnt  <= (state == HOLD) ? hold_cnt + 1'b1 : '0;
            cpu_reset <= (state_nx != RUN);
            done      <= (state_nx == DONE);
            if (restart_ok) begin
                pass      <= 1'b0;
                timeout   <= 1'b0;
                stalled   <= 1'b0;
                exit_code <= '0;
            end else if (in_run && (state_nx == DONE)) begin
                // Exactly one cause flag: tohost beats stall beats timeout.
                if (tohost_hit) begin
                    pass      <= tohost_pass;
                    exit_code <= tohost_pass ? '0 : (mon_data >> EXIT_SHIFT);
                end else if (stall_hit) begin
                    stalled <= 1'b1;
                end else begin
                    timeout <= 1'b1;
                end
            end
        end
    end

endmodule
